// File: rtl/reg_file_ctx.sv
// General-purpose register file: two registered read ports, dedicated R0 port, write bypass,
// and a shadow bank that a small FSM fills or drains one entry per clock on context switch.
module reg_file_ctx #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] r0_rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r0_wr_en,
    input  logic [DATA_W-1:0] r0_wr_data,
    input  logic              ctx_save,
    input  logic              ctx_restore,
    output logic              ctx_busy,
    output logic              ctx_done
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_main   [NUM_REGS];
    logic [DATA_W-1:0] r_shadow [NUM_REGS];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [DATA_W-1:0] r_r0_rd_data;
    logic              w_idle;
    logic              w_busy;
    logic              w_done;
    logic              w_wr_gen;
    logic              w_wr_r0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ctx_save) begin
                    w_next = S_SAVE;
                end else if (ctx_restore) begin
                    w_next = S_RESTORE;
                end
            end
            S_SAVE, S_RESTORE: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:            w_idle = 1'b1;
            S_SAVE, S_RESTORE: w_busy = 1'b1;
            S_DONE:            w_done = 1'b1;
            default:           w_idle = 1'b0;
        endcase
    end

    // Writes are only honoured in IDLE; DONE and the copy states drop them.
    assign w_wr_gen = wr_en && w_idle;
    assign w_wr_r0  = r0_wr_en && w_idle;

    // R0 port has priority over a general write to address 0, both in storage and bypass.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        if (w_wr_r0 && (a == '0)) begin
            return r0_wr_data;
        end else if (w_wr_gen && (a == wr_addr)) begin
            return wr_data;
        end else begin
            return r_main[a];
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_main[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_idx        <= '0;
            r_rd_data1   <= '0;
            r_rd_data2   <= '0;
            r_r0_rd_data <= '0;
        end else begin
            r_rd_data1   <= f_read(rd_addr1);
            r_rd_data2   <= f_read(rd_addr2);
            r_r0_rd_data <= f_read('0);

            if (w_busy) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_SAVE) begin
                r_shadow[r_idx] <= r_main[r_idx];
            end
            if (r_state == S_RESTORE) begin
                r_main[r_idx] <= r_shadow[r_idx];
            end

            if (w_wr_gen) begin
                r_main[wr_addr] <= wr_data;
            end
            if (w_wr_r0) begin
                r_main[0] <= r0_wr_data;
            end
        end
    end

    assign rd_data1   = r_rd_data1;
    assign rd_data2   = r_rd_data2;
    assign r0_rd_data = r_r0_rd_data;
    assign ctx_busy   = w_busy;
    assign ctx_done   = w_done;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Scoreboard bench for reg_file_ctx: stimulus pushes expected read results, a negedge monitor pops and compares.
module tb_reg_file_ctx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] r0_wr_data = '0;
    logic        wr_en = 1'b0;
    logic        r0_wr_en = 1'b0;
    logic        ctx_save = 1'b0;
    logic        ctx_restore = 1'b0;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic [15:0] r0_rd_data;
    logic        ctx_busy;
    logic        ctx_done;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e0;
    } exp_t;

    exp_t sb[$];
    logic chk_vld = 1'b0;
    logic chk_vld_q = 1'b0;

    reg_file_ctx #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .r0_rd_data(r0_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r0_wr_en(r0_wr_en), .r0_wr_data(r0_wr_data),
        .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // A read request travels one cycle alongside the DUT's registered read path.
    always @(posedge clk) chk_vld_q <= chk_vld;

    always @(negedge clk) begin
        exp_t e;
        if (ctx_busy) busy_cnt++;
        if (ctx_done) done_cnt++;
        if (chk_vld_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd_data1[%0d]", e.a1), 32'(rd_data1), 32'(e.e1));
                chk($sformatf("rd_data2[%0d]", e.a2), 32'(rd_data2), 32'(e.e2));
                chk("r0_rd_data", 32'(r0_rd_data), 32'(e.e0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        r0_wr_en = 1'b0;
        ctx_save = 1'b0;
        ctx_restore = 1'b0;
        chk_vld = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e0);
        rd_addr1 = a1;
        rd_addr2 = a2;
        chk_vld = 1'b1;
        sb.push_back('{a1, a2, e1, e2, e0});
        step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic ctx_op(input logic save, input logic restore, input string name);
        busy_cnt = 0;
        done_cnt = 0;
        ctx_save = save;
        ctx_restore = restore;
        step();
        wait_done(name);
        repeat (2) step();
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_busy", 32'(ctx_busy), 32'd0);
        chk("reset_done", 32'(ctx_done), 32'd0);
        chk("reset_rd_data1", 32'(rd_data1), 32'd0);
        chk("reset_r0", 32'(r0_rd_data), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 16'h0000, 16'h0000, 16'h0000);

        // bypass on port 1, then plain read
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h7B18;
        rd(4'd1, 4'd0, 16'h7B18, 16'h0000, 16'h0000);
        rd(4'd1, 4'd1, 16'h7B18, 16'h7B18, 16'h0000);

        // collision on R0
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1111;
        r0_wr_en = 1'b1; r0_wr_data = 16'h2222;
        rd(4'd0, 4'd0, 16'h2222, 16'h2222, 16'h2222);
        rd(4'd1, 4'd0, 16'h7B18, 16'h2222, 16'h2222);

        // general write to nonzero address together with R0 write
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0002;
        r0_wr_en = 1'b1; r0_wr_data = 16'h2222;
        rd(4'd2, 4'd0, 16'h0002, 16'h2222, 16'h2222);

        for (int i = 1; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        rd(4'd5, 4'd15, 16'h1005, 16'h100F, 16'h2222);
        ctx_op(1'b1, 1'b0, "save");

        for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF);
        rd(4'd0, 4'd5, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        ctx_op(1'b0, 1'b1, "restore");
        rd(4'd5, 4'd15, 16'h1005, 16'h100F, 16'h2222);
        rd(4'd0, 4'd1, 16'h2222, 16'h1001, 16'h2222);

        // write and restore request during SAVE are both ignored
        busy_cnt = 0;
        done_cnt = 0;
        ctx_save = 1'b1;
        step();
        step();
        step();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hDEAD;
        ctx_restore = 1'b1;
        step();
        wait_done("save_ign");
        repeat (20) step();
        chk("save_ign_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("save_ign_done_pulses", 32'(done_cnt), 32'd1);
        rd(4'd3, 4'd4, 16'h1003, 16'h1004, 16'h2222);

        // simultaneous save+restore: save wins
        wr(4'd7, 16'h7777);
        ctx_op(1'b1, 1'b1, "both");
        rd(4'd7, 4'd6, 16'h7777, 16'h1006, 16'h2222);
        wr(4'd7, 16'h0001);
        rd(4'd7, 4'd0, 16'h0001, 16'h2222, 16'h2222);
        ctx_op(1'b0, 1'b1, "both_restore");
        rd(4'd7, 4'd0, 16'h7777, 16'h2222, 16'h2222);

        // reset mid-SAVE
        ctx_save = 1'b1;
        step();
        step();
        step();
        chk("midsave_busy_before", 32'(ctx_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midsave_busy_after_reset", 32'(ctx_busy), 32'd0);
        chk("midsave_done_after_reset", 32'(ctx_done), 32'd0);
        chk("midsave_rd_data2", 32'(rd_data2), 32'd0);
        #4 reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 16'h0000, 16'h0000, 16'h0000);
        ctx_op(1'b0, 1'b1, "post_reset_restore");
        rd(4'd7, 4'd15, 16'h0000, 16'h0000, 16'h0000);

        repeat (2) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_file_ctx.md
Name: reg_file_ctx

Overview:
- Parametrised general-purpose register file for the CPU datapath.
- Two registered read ports, one general write port, and a dedicated R0 (accumulator) read/write port.
- Same-cycle write-to-read bypass.
- Shadow bank with a sequential context save/restore engine for interrupt entry and exit: one register copied per clock.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W entries in both main and shadow banks

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data, registered
rd_data2  output  DATA_W  read port 2 data, registered
r0_rd_data  output  DATA_W  R0 contents, registered
wr_en  input  1  general write enable
wr_addr  input  ADDR_W  general write address
wr_data  input  DATA_W  general write data
r0_wr_en  input  1  dedicated R0 write enable
r0_wr_data  input  DATA_W  dedicated R0 write data
ctx_save  input  1  request: copy main bank to shadow bank
ctx_restore  input  1  request: copy shadow bank to main bank
ctx_busy  output  1  high while a save/restore copy is in progress
ctx_done  output  1  one-cycle pulse when a copy finishes

Behaviour:
- Reset (asynchronous, active-high):
  - All main and shadow entries go to 0.
  - rd_data1, rd_data2, r0_rd_data, ctx_busy and ctx_done go to 0.
  - FSM goes to IDLE; copy counter goes to 0.
  - Reset asserted mid-copy aborts the copy immediately; no partial-state guarantees are needed beyond all-zero.
- Reads:
  - 1-cycle latency: address sampled at edge N, data valid after edge N.
  - r0_rd_data follows the same timing.
- Write bypass:
  - If a write to address A is accepted at edge N and a read of A is sampled at edge N, the read returns the new write data.
  - This applies to both read ports and to r0_rd_data.
- Write acceptance:
  - Writes are accepted only when the FSM is IDLE at the sampling edge.
  - wr_en and r0_wr_en are silently dropped while ctx_busy is high.
- Write collision:
  - wr_en with wr_addr=0 and r0_wr_en at the same edge: r0_wr_data wins, and the bypass returns r0_wr_data.
  - wr_en to a nonzero address together with r0_wr_en: both writes happen.
- FSM states: IDLE, SAVE, RESTORE, DONE.
  - IDLE -> SAVE on ctx_save. IDLE -> RESTORE on ctx_restore (when ctx_save is low).
  - If both requests are high in IDLE, ctx_save wins and ctx_restore is dropped.
  - Requests arriving outside IDLE are ignored; requests are level-sampled, not queued.
  - The request edge itself is still an IDLE edge, so a write at that edge is accepted.
- Copy phase (SAVE/RESTORE):
  - ctx_busy is high for exactly NUM_REGS cycles.
  - At each edge, entry idx is copied (main->shadow for SAVE, shadow->main for RESTORE), then idx increments.
  - Entries are copied in order 0..NUM_REGS-1. After idx = NUM_REGS-1 is copied, the counter wraps to 0 and the FSM goes to DONE.
- DONE: ctx_busy is 0, ctx_done is 1 for one cycle, then the FSM returns to IDLE. Requests are not accepted in DONE.
- Reads during copy:
  - Read ports keep working during a copy and read the main bank as it currently stands.
  - During RESTORE, a read may return an old or already-restored value depending on idx.
  - There is no bypass from copy traffic.
- Request-to-IDLE latency: edge N samples the request; copies happen at edges N+1..N+NUM_REGS; ctx_done is high in the cycle after edge N+NUM_REGS; the FSM is back in IDLE at edge N+NUM_REGS+1.

Test Plan:
- Reset then read all 16 addresses -> every rd_data1/rd_data2/r0_rd_data = 0x0000. Assert reset mid-SAVE -> ctx_busy falls to 0 immediately, all registers read 0.
- Write 0x7B18 to R1 at edge N while rd_addr1=1 at edge N -> rd_data1=0x7B18 after edge N (bypass). Read R1 again next cycle -> 0x7B18.
- Same edge: wr_en, wr_addr=0, wr_data=0x1111, r0_wr_en, r0_wr_data=0x2222 -> R0 reads 0x2222 on r0_rd_data and rd_data2 (rd_addr2=0).
- Load R1..R15 with 0x1000+i, then pulse ctx_save -> ctx_busy high exactly 16 cycles, ctx_done a single pulse. Overwrite all registers with 0xFFFF, pulse ctx_restore -> R5 reads 0x1005, R15 reads 0x100F.
- During SAVE, drive wr_en to R3 with 0xDEAD and pulse ctx_restore -> R3 unchanged, restore not started (ctx_done pulses once, ctx_busy never re-asserts).
- ctx_save and ctx_restore both high in IDLE -> SAVE executes: shadow updated, main unchanged.
